system_0_sysid_ext: RTL and testbench
=====================================

# system_0_sysid_ext

Parametrised system-identification and uptime slave on the Avalon-MM control fabric of `system_0`. It returns a build ID and a build timestamp, and adds what a bare ID block lacks: a free-running prescaled 64-bit uptime counter with atomic two-word reads, a read/write scratch register, and counter freeze/clear control. Software uses it to check that the loaded image matches the driver and to time-stamp events.

## Interface
Parameters:
- `ID_VALUE`, 32'h0: system ID constant.
- `TIMESTAMP`, 32'h0: build time in Unix seconds.
- `TICK_DIV`, 50: clocks per uptime tick. Legal range 1..65535; 50 gives 1 µs at 50 MHz.
- `SCRATCH_RESET`, 32'h0: reset value of SCRATCH.

Ports (clock and reset first):
- `clock`  in  1  single system clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `address`  in  3  word address.
- `read`  in  1  read strobe, one cycle per access.
- `write`  in  1  write strobe, one cycle per access.
- `writedata`  in  32  write data.
- `readdata`  out  32  registered read data.
- `readdatavalid`  out  1  high for one cycle when `readdata` is valid.

## Operation
Register map (word addresses):
- 0 ID: read-only, returns `ID_VALUE`.
- 1 TIMESTAMP: read-only, returns `TIMESTAMP`.
- 2 UPTIME_LO: read-only, returns counter[31:0]. The same read copies counter[63:32] into the HI shadow.
- 3 UPTIME_HI: read-only, returns the HI shadow, not the live counter.
- 4 SCRATCH: read/write, 32 bits.
- 5 CTRL:
  - bit0 FREEZE: read/write.
  - bit1 CLEAR: write-1 pulse, always reads 0.
  - bits[31:2]: read 0.
- 6, 7: reserved. Reads return 0 and writes are ignored.
- Writes to read-only addresses are ignored.

Prescaler and counter:
- The prescaler counts 0..`TICK_DIV`-1.
- On terminal count the prescaler returns to 0 and the 64-bit counter increments by 1.
- The counter wraps from 2^64-1 to 0 with no flag.
- FREEZE=1 holds both the prescaler and the counter.

CLEAR:
- A write to CTRL with bit1=1 zeroes the prescaler, the counter and the HI shadow in the cycle after the write.
- In the same write, FREEZE takes writedata[0].
- CLEAR takes priority over the increment that cycle.

## Timing
- Fixed read latency of 1. A read at cycle N puts data on `readdata` with `readdatavalid`=1 at N+1.
- `readdata` holds its value until the next read.
- A UPTIME_LO read returns the counter value as registered at edge N, i.e. before any increment at that edge. The shadow captures the upper word from the same snapshot, so LO then HI is always coherent.
- Writes take effect at the clock edge of the write cycle.
- Simultaneous `read` and `write` to the same address: the read returns the pre-write value and the write still takes effect.
- `TICK_DIV`=1: the counter increments every unfrozen cycle.
- Reset values:
  - `readdata`=0, `readdatavalid`=0.
  - counter, prescaler and shadow = 0.
  - SCRATCH=`SCRATCH_RESET`.
  - FREEZE=0.
- Reset asserted mid-operation clears all state immediately, with no clock needed. A read in flight is dropped and no `readdatavalid` is issued for it.
- Counting restarts on the first rising edge after `reset_n` rises.

## Configuration
- Macro `SYSID_UPTIME_EN`.
- Defined: prescaler, counter, shadow and CTRL are implemented as described above.
- Undefined:
  - Prescaler, counter and shadow are not built.
  - Addresses 2, 3 and 5 read 0 and ignore writes.
  - ID, TIMESTAMP, SCRATCH and the read latency are unchanged.

## Structure
- Shared package `sysid_pkg` holds:
  - address constants `SYSID_ADDR_ID` .. `SYSID_ADDR_CTRL`;
  - CTRL bit indices `SYSID_CTRL_FREEZE`=0 and `SYSID_CTRL_CLEAR`=1;
  - the counter width constant `SYSID_UPTIME_W`=64.
- One sub-module, `sysid_uptime_ctr`:
  - contains the prescaler, the 64-bit counter and the shadow capture;
  - inputs: freeze, clear, snapshot;
  - outputs: lo, hi_shadow;
  - instantiated only under `SYSID_UPTIME_EN`.
- The top level holds the address decode, SCRATCH, CTRL and the read-data register.

## Test plan
- Reset, then read addresses 0 and 1 with `ID_VALUE`=32'h63A2_1F99 -> 32'h63A2_1F99, then `TIMESTAMP`, each with `readdatavalid` at N+1 only.
- Write 32'hDEAD_BEEF to address 4, read back -> 32'hDEAD_BEEF. Write 32'h1234 to address 0 -> address 0 still reads `ID_VALUE`.
- `TICK_DIV`=4, run 40 cycles after reset, read LO -> 10 (±1 depending on the read edge). With FREEZE=1 for 100 cycles, LO is unchanged.
- Force the counter to 64'h0000_0000_FFFF_FFFF before a tick. Read LO on the wrap cycle, then HI two cycles later -> the (LO, HI) pair is either (FFFF_FFFF, 0) or (0, 1), never (0, 0).
- Write CTRL=32'h3 -> counter reads 0 and FREEZE reads 1. Write CTRL=32'h0 -> counting resumes. CTRL bit1 always reads 0.
- Pulse `reset_n` low mid-read -> no `readdatavalid`, SCRATCH returns to `SCRATCH_RESET`, uptime reads 0.
- Build without `SYSID_UPTIME_EN` -> addresses 2, 3 and 5 read 0.

Source files
------------

// File: rtl/sysid_pkg.sv
// ---------------------------------------------------------------------------
// sysid_pkg
//   Shared constants for the system_0 system-ID / uptime slave:
//   word addresses of the register map, CTRL bit positions and the uptime
//   counter geometry. Imported by system_0_sysid_ext and sysid_uptime_ctr.
// ---------------------------------------------------------------------------
package sysid_pkg;

    // Register map (word addresses on the 3-bit Avalon-MM address bus)
    localparam logic [2:0] SYSID_ADDR_ID        = 3'd0;
    localparam logic [2:0] SYSID_ADDR_TIMESTAMP = 3'd1;
    localparam logic [2:0] SYSID_ADDR_UPTIME_LO = 3'd2;
    localparam logic [2:0] SYSID_ADDR_UPTIME_HI = 3'd3;
    localparam logic [2:0] SYSID_ADDR_SCRATCH   = 3'd4;
    localparam logic [2:0] SYSID_ADDR_CTRL      = 3'd5;

    // CTRL register bit positions
    localparam int SYSID_CTRL_FREEZE = 0;
    localparam int SYSID_CTRL_CLEAR  = 1;

    // Uptime counter width and prescaler width (TICK_DIV is at most 65535)
    localparam int SYSID_UPTIME_W = 64;
    localparam int SYSID_PRESC_W  = 16;

endpackage

// File: rtl/sysid_uptime_ctr.sv
// ---------------------------------------------------------------------------
// sysid_uptime_ctr
//   Prescaled 64-bit free-running uptime counter with a high-word shadow.
//   The prescaler counts 0..TICK_DIV-1; on its terminal count the counter
//   increments (wrapping silently at 2^64-1). A snapshot copies the live upper
//   word into the shadow in the same cycle the lower word is being read, so a
//   LO-then-HI software read pair is always coherent.
//
//   Parameters:
//     TICK_DIV   clocks per uptime tick, 1..65535
//   Ports:
//     clock      system clock
//     reset_n    asynchronous active-low reset
//     freeze     holds prescaler and counter while high
//     clear      zeroes prescaler, counter and shadow (wins over increment)
//     snapshot   copy counter[63:32] into the shadow
//     lo         live counter[31:0]
//     hi_shadow  captured upper word
// ---------------------------------------------------------------------------
module sysid_uptime_ctr
    import sysid_pkg::*;
#(
    parameter int unsigned TICK_DIV = 50
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        freeze,
    input  logic        clear,
    input  logic        snapshot,
    output logic [31:0] lo,
    output logic [31:0] hi_shadow
);

    localparam logic [SYSID_PRESC_W-1:0] PRESC_LAST = SYSID_PRESC_W'(TICK_DIV - 1);

    logic [SYSID_PRESC_W-1:0]  presc_q;
    logic [SYSID_UPTIME_W-1:0] count_q;
    logic [31:0]               shadow_q;
    logic                      tick;

    // With TICK_DIV=1 PRESC_LAST is 0, so every unfrozen cycle is a tick.
    assign tick = !freeze && (presc_q == PRESC_LAST);

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values; blocking here would create order-dependent simulation.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            presc_q  <= '0;
            count_q  <= '0;
            shadow_q <= '0;
        end else if (clear) begin
            presc_q  <= '0;
            count_q  <= '0;
            shadow_q <= '0;
        end else begin
            if (!freeze) begin
                presc_q <= tick ? '0 : presc_q + 1'b1;
            end
            if (tick) begin
                count_q <= count_q + 1'b1;
            end
            // Capture uses the pre-increment value, matching what LO returns.
            if (snapshot) begin
                shadow_q <= count_q[SYSID_UPTIME_W-1:32];
            end
        end
    end

    assign lo        = count_q[31:0];
    assign hi_shadow = shadow_q;

endmodule

// File: rtl/system_0_sysid_ext.sv
// ---------------------------------------------------------------------------
// system_0_sysid_ext
//   Avalon-MM slave returning a build ID and build timestamp, plus a 32-bit
//   scratch register and (optionally) a prescaled 64-bit uptime counter with
//   freeze/clear control. Fixed read latency of one clock.
//
//   Optional feature macro: SYSID_UPTIME_EN
//     defined   -> uptime counter, HI shadow and CTRL are built
//     undefined -> addresses 2, 3 and 5 read 0 and ignore writes
//
//   Parameters:
//     ID_VALUE       system ID constant (address 0)
//     TIMESTAMP      build time, Unix seconds (address 1)
//     TICK_DIV       clocks per uptime tick, 1..65535
//     SCRATCH_RESET  reset value of SCRATCH (address 4)
//   Ports:
//     clock          system clock
//     reset_n        asynchronous active-low reset
//     address        word address
//     read           read strobe, one cycle per access
//     write          write strobe, one cycle per access
//     writedata      write data
//     readdata       registered read data, held until the next read
//     readdatavalid  one-cycle pulse when readdata is valid
// ---------------------------------------------------------------------------
module system_0_sysid_ext
    import sysid_pkg::*;
#(
    parameter logic [31:0] ID_VALUE      = 32'h0,
    parameter logic [31:0] TIMESTAMP     = 32'h0,
    parameter int unsigned TICK_DIV      = 50,
    parameter logic [31:0] SCRATCH_RESET = 32'h0
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [2:0]  address,
    input  logic        read,
    input  logic        write,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        readdatavalid
);

    // Elaboration-time guard on the prescaler range.
    if (TICK_DIV < 1 || TICK_DIV > 65535) begin : g_bad_tick_div
        $error("system_0_sysid_ext: TICK_DIV must be in 1..65535");
    end

    logic [31:0] scratch_q;
    logic [31:0] rd_mux;

    // -----------------------------------------------------------------------
    // SCRATCH register
    // -----------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            scratch_q <= SCRATCH_RESET;
        end else if (write && address == SYSID_ADDR_SCRATCH) begin
            scratch_q <= writedata;
        end
    end

`ifdef SYSID_UPTIME_EN
    // -----------------------------------------------------------------------
    // CTRL and uptime counter
    // -----------------------------------------------------------------------
    logic        freeze_q;
    logic        ctrl_wr;
    logic        clear_pulse;
    logic        snapshot;
    logic [31:0] up_lo;
    logic [31:0] up_hi;

    assign ctrl_wr     = write && (address == SYSID_ADDR_CTRL);
    // CLEAR is not stored: it acts at the write edge and always reads back 0.
    assign clear_pulse = ctrl_wr && writedata[SYSID_CTRL_CLEAR];
    assign snapshot    = read && (address == SYSID_ADDR_UPTIME_LO);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            freeze_q <= 1'b0;
        end else if (ctrl_wr) begin
            freeze_q <= writedata[SYSID_CTRL_FREEZE];
        end
    end

    sysid_uptime_ctr #(
        .TICK_DIV (TICK_DIV)
    ) u_uptime (
        .clock     (clock),
        .reset_n   (reset_n),
        .freeze    (freeze_q),
        .clear     (clear_pulse),
        .snapshot  (snapshot),
        .lo        (up_lo),
        .hi_shadow (up_hi)
    );
`endif

    // -----------------------------------------------------------------------
    // Read-data mux; registering it gives the fixed one-cycle latency and
    // naturally returns the pre-write value on a same-address read+write.
    // -----------------------------------------------------------------------
    // NOTE: rd_mux gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        rd_mux = '0;
        case (address)
            SYSID_ADDR_ID:        rd_mux = ID_VALUE;
            SYSID_ADDR_TIMESTAMP: rd_mux = TIMESTAMP;
            SYSID_ADDR_SCRATCH:   rd_mux = scratch_q;
`ifdef SYSID_UPTIME_EN
            SYSID_ADDR_UPTIME_LO: rd_mux = up_lo;
            SYSID_ADDR_UPTIME_HI: rd_mux = up_hi;
            SYSID_ADDR_CTRL:      rd_mux[SYSID_CTRL_FREEZE] = freeze_q;
`else
            SYSID_ADDR_UPTIME_LO,
            SYSID_ADDR_UPTIME_HI,
            SYSID_ADDR_CTRL:      rd_mux = '0;
`endif
            default:              rd_mux = '0;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            readdata      <= '0;
            readdatavalid <= 1'b0;
        end else begin
            readdatavalid <= read;
            if (read) begin
                readdata <= rd_mux;
            end
        end
    end

endmodule

// File: tb/tb_system_0_sysid_ext.sv
// ---------------------------------------------------------------------------
// tb_system_0_sysid_ext
//   Directed self-checking bench for system_0_sysid_ext with ID_VALUE =
//   32'h63A2_1F99 and TICK_DIV = 4. Inputs change on the falling edge, the
//   DUT samples on the rising edge, outputs are checked on the next falling
//   edge. Uptime checks are built only when SYSID_UPTIME_EN is defined;
//   otherwise addresses 2, 3 and 5 are checked to read 0.
// ---------------------------------------------------------------------------
module tb_system_0_sysid_ext;
    import sysid_pkg::*;

    localparam logic [31:0] P_ID      = 32'h63A2_1F99;
    localparam logic [31:0] P_TS      = 32'h6512_3456;
    localparam int unsigned P_DIV     = 4;
    localparam logic [31:0] P_SCR_RST = 32'hA5A5_0001;

    logic        clock;
    logic        reset_n;
    logic [2:0]  address;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        readdatavalid;

    int total = 0;
    int bad   = 0;

    system_0_sysid_ext #(
        .ID_VALUE      (P_ID),
        .TIMESTAMP     (P_TS),
        .TICK_DIV      (P_DIV),
        .SCRATCH_RESET (P_SCR_RST)
    ) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .address       (address),
        .read          (read),
        .write         (write),
        .writedata     (writedata),
        .readdata      (readdata),
        .readdatavalid (readdatavalid)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reset released on a falling edge; the first counting edge follows.
    task automatic do_reset();
        reset_n = 1'b0;
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
    endtask

    task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
        @(negedge clock);
        address   = a;
        writedata = d;
        write     = 1'b1;
        @(negedge clock);
        write     = 1'b0;
    endtask

    // Read issued for one cycle; data and valid sampled one cycle later.
    task automatic bus_read(input logic [2:0] a, output logic [31:0] d, output logic v);
        @(negedge clock);
        address = a;
        read    = 1'b1;
        @(negedge clock);
        read    = 1'b0;
        d       = readdata;
        v       = readdatavalid;
    endtask

    task automatic rd_check(input string tag, input logic [2:0] a, input logic [31:0] exp);
        logic [31:0] d;
        logic        v;
        bus_read(a, d, v);
        check({tag, "_data"}, 64'(d), 64'(exp));
        check({tag, "_valid"}, 64'(v), 64'd1);
    endtask

    initial begin
        logic [31:0] d;
        logic        v;

        reset_n   = 1'b0;
        address   = '0;
        read      = 1'b0;
        write     = 1'b0;
        writedata = '0;

        // ---------------- reset state ----------------
        #1;
        check("rst_readdata", 64'(readdata), 64'd0);
        check("rst_valid", 64'(readdatavalid), 64'd0);
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        check("post_rst_valid", 64'(readdatavalid), 64'd0);

        // ---------------- ID / TIMESTAMP ----------------
        rd_check("id", SYSID_ADDR_ID, P_ID);
        @(negedge clock);
        check("id_valid_drop", 64'(readdatavalid), 64'd0);
        check("id_data_hold", 64'(readdata), 64'(P_ID));
        rd_check("ts", SYSID_ADDR_TIMESTAMP, P_TS);
        @(negedge clock);
        check("ts_valid_drop", 64'(readdatavalid), 64'd0);

        // ---------------- SCRATCH and read-only writes ----------------
        rd_check("scr_rst", SYSID_ADDR_SCRATCH, P_SCR_RST);
        bus_write(SYSID_ADDR_SCRATCH, 32'hDEAD_BEEF);
        rd_check("scr_wr", SYSID_ADDR_SCRATCH, 32'hDEAD_BEEF);
        bus_write(SYSID_ADDR_ID, 32'h0000_1234);
        rd_check("id_ro", SYSID_ADDR_ID, P_ID);
        bus_write(SYSID_ADDR_TIMESTAMP, 32'h0000_5678);
        rd_check("ts_ro", SYSID_ADDR_TIMESTAMP, P_TS);

        // Simultaneous read+write to SCRATCH: old value returned, write lands.
        @(negedge clock);
        address   = SYSID_ADDR_SCRATCH;
        writedata = 32'h0BAD_F00D;
        read      = 1'b1;
        write     = 1'b1;
        @(negedge clock);
        read      = 1'b0;
        write     = 1'b0;
        check("rw_old_data", 64'(readdata), 64'hDEAD_BEEF);
        rd_check("rw_new", SYSID_ADDR_SCRATCH, 32'h0BAD_F00D);

        // Reserved addresses
        bus_write(3'd6, 32'hFFFF_FFFF);
        rd_check("rsv6", 3'd6, 32'h0);
        rd_check("rsv7", 3'd7, 32'h0);

`ifdef SYSID_UPTIME_EN
        // ---------------- uptime counting ----------------
        do_reset();
        repeat (40) @(posedge clock);
        // Read sampled at edge 41 returns the count after 40 edges: 40/4.
        rd_check("up_40", SYSID_ADDR_UPTIME_LO, 32'd10);
        rd_check("up_40_hi", SYSID_ADDR_UPTIME_HI, 32'd0);

        // Freeze write lands at edge 43: 43 counted edges -> 10 ticks.
        do_reset();
        repeat (40) @(posedge clock);
        bus_read(SYSID_ADDR_UPTIME_LO, d, v);
        bus_write(SYSID_ADDR_CTRL, 32'h1);
        repeat (100) @(negedge clock);
        rd_check("freeze_hold", SYSID_ADDR_UPTIME_LO, 32'd10);
        rd_check("ctrl_freeze", SYSID_ADDR_CTRL, 32'h1);

        // ---------------- CLEAR ----------------
        bus_write(SYSID_ADDR_CTRL, 32'h3);
        rd_check("clr_lo", SYSID_ADDR_UPTIME_LO, 32'd0);
        rd_check("clr_hi", SYSID_ADDR_UPTIME_HI, 32'd0);
        rd_check("clr_ctrl", SYSID_ADDR_CTRL, 32'h1);
        // Unfreeze at edge W; read sampled at W+22 sees 21 edges -> 5 ticks.
        bus_write(SYSID_ADDR_CTRL, 32'h0);
        repeat (20) @(negedge clock);
        rd_check("resume", SYSID_ADDR_UPTIME_LO, 32'd5);
        rd_check("ctrl_zero", SYSID_ADDR_CTRL, 32'h0);

        // ---------------- 32-bit carry coherence ----------------
        bus_write(SYSID_ADDR_CTRL, 32'h3);
        @(negedge clock);
        force dut.u_uptime.count_q = 64'h0000_0000_FFFF_FFFF;
        @(negedge clock);
        release dut.u_uptime.count_q;
        @(negedge clock);
        // Unfreeze at edge W; the carry happens at W+4, LO read sampled there.
        bus_write(SYSID_ADDR_CTRL, 32'h0);
        repeat (2) @(negedge clock);
        rd_check("wrap_lo", SYSID_ADDR_UPTIME_LO, 32'hFFFF_FFFF);
        rd_check("wrap_hi", SYSID_ADDR_UPTIME_HI, 32'h0);
        rd_check("wrap_lo2", SYSID_ADDR_UPTIME_LO, 32'h0);
        rd_check("wrap_hi2", SYSID_ADDR_UPTIME_HI, 32'h1);
`else
        // ---------------- uptime disabled ----------------
        bus_write(SYSID_ADDR_CTRL, 32'h3);
        bus_write(SYSID_ADDR_UPTIME_LO, 32'h1111_1111);
        repeat (10) @(negedge clock);
        rd_check("off_lo", SYSID_ADDR_UPTIME_LO, 32'h0);
        rd_check("off_hi", SYSID_ADDR_UPTIME_HI, 32'h0);
        rd_check("off_ctrl", SYSID_ADDR_CTRL, 32'h0);
`endif

        // ---------------- reset mid-read ----------------
        bus_write(SYSID_ADDR_SCRATCH, 32'h1357_9BDF);
        // Valid already up, then reset clears it with no clock edge.
        @(negedge clock);
        address = SYSID_ADDR_SCRATCH;
        read    = 1'b1;
        @(posedge clock);
        #2;
        check("mid_pre_valid", 64'(readdatavalid), 64'd1);
        reset_n = 1'b0;
        read    = 1'b0;
        #1;
        check("mid_async_valid", 64'(readdatavalid), 64'd0);
        check("mid_async_data", 64'(readdata), 64'd0);
        @(negedge clock);
        reset_n = 1'b1;

        // Read strobe present when reset hits before the sampling edge.
        @(negedge clock);
        address = SYSID_ADDR_ID;
        read    = 1'b1;
        #2;
        reset_n = 1'b0;
        @(negedge clock);
        read    = 1'b0;
        check("mid_drop_valid", 64'(readdatavalid), 64'd0);
        reset_n = 1'b1;
        rd_check("mid_scr_rst", SYSID_ADDR_SCRATCH, P_SCR_RST);
`ifdef SYSID_UPTIME_EN
        rd_check("mid_up_lo", SYSID_ADDR_UPTIME_LO, 32'd0);
        rd_check("mid_up_hi", SYSID_ADDR_UPTIME_HI, 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
